// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures writeback candidates, aligns and extends load
// data, qualifies the register-file write enable and counts retired instructions.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [1:0]      in_addr_lo,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_wb_src,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  output logic            wb_valid,
  output logic [2:0]      wb_sel,
  output logic [XLEN-1:0] wb_alu,
  output logic [XLEN-1:0] wb_load,
  output logic [XLEN-1:0] wb_pc4,
  output logic [XLEN-1:0] wb_imm,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            wb_misaligned,
  output logic [63:0]     instret
);

  localparam logic [2:0] SRC_LOAD = 3'b001;
  localparam logic [2:0] F3_LB    = 3'b000;
  localparam logic [2:0] F3_LH    = 3'b001;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;

  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      lo,
                                                  input logic [2:0]      f3);
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;
    logic [XLEN-1:0]    res;
    case (lo)
      2'd0:    sbyte = word[7:0];
      2'd1:    sbyte = word[15:8];
      2'd2:    sbyte = word[23:16];
      default: sbyte = word[31:24];
    endcase
    shalf = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res = XLEN'(sbyte);
      F3_LBU:  res = {{(XLEN-8){1'b0}}, sbyte};
      F3_LH:   res = XLEN'(shalf);
      F3_LHU:  res = {{(XLEN-16){1'b0}}, shalf};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] src,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic half_bad;
    logic word_bad;
    half_bad = ((f3 == F3_LH) || (f3 == F3_LHU)) && lo[0];
    word_bad = (f3 == F3_LW) && (lo != 2'b00);
    return (src == SRC_LOAD) && (half_bad || word_bad);
  endfunction

  // Stage p0: combinational candidates ahead of the register
  logic [XLEN-1:0] load_p0;
  logic            mis_p0;
  logic            reg_write_p0;

  always_comb begin
    load_p0      = align_load(in_mem_rdata, in_addr_lo, in_funct3);
    mis_p0       = is_misaligned(in_wb_src, in_funct3, in_addr_lo);
    // Reserved sources (1xx) have no defined result, so they never write rd
    reg_write_p0 = in_valid & in_reg_write & (in_rd != 5'd0) & ~mis_p0 & ~in_wb_src[2];
  end

  // Stage p1: registered writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_sel        <= 3'b000;
      wb_alu        <= '0;
      wb_load       <= '0;
      wb_pc4        <= '0;
      wb_imm        <= '0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_sel        <= 3'b000;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= in_valid;
      wb_sel        <= in_wb_src;
      wb_alu        <= in_alu;
      wb_load       <= load_p0;
      wb_pc4        <= in_pc4;
      wb_imm        <= in_imm;
      wb_rd         <= in_rd;
      wb_reg_write  <= reg_write_p0;
      wb_misaligned <= mis_p0;
    end
  end

  // Counts the instruction leaving writeback on this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (!stall && wb_valid && !wb_misaligned) begin
      instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for capture/alignment plus
// hand-written reset, stall, flush and retire-counter sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write;
  logic [31:0] in_alu, in_mem_rdata, in_pc4, in_imm;
  logic [1:0]  in_addr_lo;
  logic [2:0]  in_funct3, in_wb_src;
  logic [4:0]  in_rd;
  logic        wb_valid, wb_reg_write, wb_misaligned;
  logic [2:0]  wb_sel;
  logic [31:0] wb_alu, wb_load, wb_pc4, wb_imm;
  logic [4:0]  wb_rd;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_alu(in_alu), .in_mem_rdata(in_mem_rdata),
    .in_addr_lo(in_addr_lo), .in_funct3(in_funct3), .in_pc4(in_pc4),
    .in_imm(in_imm), .in_wb_src(in_wb_src), .in_rd(in_rd),
    .in_reg_write(in_reg_write),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_alu(wb_alu), .wb_load(wb_load),
    .wb_pc4(wb_pc4), .wb_imm(wb_imm), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_misaligned(wb_misaligned),
    .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [1:0]  lo;
    logic [2:0]  f3;
    logic [2:0]  src;
    logic [4:0]  rd;
    logic        rw;
    logic        e_v;
    logic [31:0] e_load;
    logic        e_rw;
    logic        e_mis;
    logic [63:0] e_ir;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic v, logic [31:0] alu, logic [31:0] rdata,
                              logic [1:0] lo, logic [2:0] f3, logic [2:0] src,
                              logic [4:0] rd, logic rw, logic e_v,
                              logic [31:0] e_load, logic e_rw, logic e_mis,
                              logic [63:0] e_ir);
    vec_t t;
    t.v = v; t.alu = alu; t.rdata = rdata; t.lo = lo; t.f3 = f3; t.src = src;
    t.rd = rd; t.rw = rw; t.e_v = e_v; t.e_load = e_load; t.e_rw = e_rw;
    t.e_mis = e_mis; t.e_ir = e_ir;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [31:0] alu, input logic [4:0] rd);
    in_valid = v; in_alu = alu; in_mem_rdata = 32'h0; in_addr_lo = 2'b00;
    in_funct3 = 3'b010; in_wb_src = 3'b000; in_rd = rd; in_reg_write = 1'b1;
    in_pc4 = 32'h0; in_imm = 32'h0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_alu(1'b0, 32'h0, 5'd0);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_alu = $urandom; in_mem_rdata = $urandom;
      in_addr_lo = 2'($urandom); in_funct3 = 3'($urandom); in_wb_src = 3'($urandom);
      in_rd = 5'($urandom); in_reg_write = 1'b1; in_pc4 = $urandom; in_imm = $urandom;
      stall = 1'($urandom); flush = 1'($urandom);
      tick();
    end
    chk("rst_valid", wb_valid, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_alu", wb_alu, 0);
    chk("rst_load", wb_load, 0);
    chk("rst_pc4", wb_pc4, 0);
    chk("rst_imm", wb_imm, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_rw", wb_reg_write, 0);
    chk("rst_mis", wb_misaligned, 0);
    chk("rst_instret", instret, 0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    //             v   alu           rdata         lo     f3      src     rd  rw  e_v e_load        e_rw e_mis e_ir
    vecs[0]  = mk(1, 32'h0,        32'hDEADBEEF, 2'b00, 3'b010, 3'b001, 5,  1,  1, 32'hDEADBEEF, 1,   0,    0);
    vecs[1]  = mk(1, 32'h0,        32'h80F17F22, 2'b01, 3'b000, 3'b001, 6,  1,  1, 32'h0000007F, 1,   0,    1);
    vecs[2]  = mk(1, 32'h0,        32'h80F17F22, 2'b10, 3'b000, 3'b001, 6,  1,  1, 32'hFFFFFFF1, 1,   0,    2);
    vecs[3]  = mk(1, 32'h0,        32'h80F17F22, 2'b11, 3'b100, 3'b001, 6,  1,  1, 32'h00000080, 1,   0,    3);
    vecs[4]  = mk(1, 32'h0,        32'h80F17F22, 2'b10, 3'b001, 3'b001, 6,  1,  1, 32'hFFFF80F1, 1,   0,    4);
    vecs[5]  = mk(1, 32'h0,        32'h80F17F22, 2'b00, 3'b101, 3'b001, 6,  1,  1, 32'h00007F22, 1,   0,    5);
    vecs[6]  = mk(1, 32'h0,        32'h80F17F22, 2'b10, 3'b010, 3'b001, 3,  1,  1, 32'h80F17F22, 0,   1,    6);
    vecs[7]  = mk(1, 32'h0,        32'h80F17F22, 2'b01, 3'b001, 3'b001, 4,  1,  1, 32'h00007F22, 0,   1,    6);
    vecs[8]  = mk(1, 32'hCAFE0001, 32'h0,        2'b00, 3'b010, 3'b000, 0,  1,  1, 32'h0,        0,   0,    6);
    vecs[9]  = mk(1, 32'h00000042, 32'h0,        2'b00, 3'b010, 3'b110, 7,  1,  1, 32'h0,        0,   0,    7);
    vecs[10] = mk(0, 32'h00000055, 32'h0,        2'b00, 3'b010, 3'b000, 8,  1,  0, 32'h0,        0,   0,    8);
    vecs[11] = mk(1, 32'h00000077, 32'h80F17F22, 2'b01, 3'b101, 3'b000, 9,  1,  1, 32'h00007F22, 1,   0,    8);

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].v; in_alu = vecs[i].alu; in_mem_rdata = vecs[i].rdata;
      in_addr_lo = vecs[i].lo; in_funct3 = vecs[i].f3; in_wb_src = vecs[i].src;
      in_rd = vecs[i].rd; in_reg_write = vecs[i].rw;
      in_pc4 = 32'h1000 + 32'(i) * 4; in_imm = 32'(i) << 12;
      tick();
      chk($sformatf("v%0d_valid", i), wb_valid, vecs[i].e_v);
      chk($sformatf("v%0d_sel", i), wb_sel, vecs[i].src);
      chk($sformatf("v%0d_alu", i), wb_alu, vecs[i].alu);
      chk($sformatf("v%0d_load", i), wb_load, vecs[i].e_load);
      chk($sformatf("v%0d_pc4", i), wb_pc4, 32'h1000 + 32'(i) * 4);
      chk($sformatf("v%0d_imm", i), wb_imm, 32'(i) << 12);
      chk($sformatf("v%0d_rd", i), wb_rd, vecs[i].rd);
      chk($sformatf("v%0d_rw", i), wb_reg_write, vecs[i].e_rw);
      chk($sformatf("v%0d_mis", i), wb_misaligned, vecs[i].e_mis);
      chk($sformatf("v%0d_instret", i), instret, vecs[i].e_ir);
    end
    drive_alu(1'b0, 32'h0, 5'd0);
    tick();
    chk("tail_instret", instret, 9);

    // Stall holds the captured ALU result and freezes instret
    drive_alu(1'b1, 32'h1234, 5'd9);
    tick();
    chk("stall_cap_alu", wb_alu, 32'h1234);
    chk("stall_cap_instret", instret, 9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 32'hA000 + 32'(i), 5'd11);
      tick();
      chk($sformatf("stall%0d_alu", i), wb_alu, 32'h1234);
      chk($sformatf("stall%0d_rd", i), wb_rd, 9);
      chk($sformatf("stall%0d_instret", i), instret, 9);
    end
    stall = 1'b0;
    drive_alu(1'b1, 32'h5678, 5'd10);
    tick();
    chk("unstall_alu", wb_alu, 32'h5678);
    chk("unstall_instret", instret, 10);

    // Stall and flush together: bubble wins, departing instruction not counted
    stall = 1'b1; flush = 1'b1;
    drive_alu(1'b1, 32'h9999, 5'd12);
    tick();
    chk("sf_valid", wb_valid, 0);
    chk("sf_rw", wb_reg_write, 0);
    chk("sf_sel", wb_sel, 0);
    chk("sf_rd", wb_rd, 0);
    chk("sf_instret", instret, 10);

    // Plain flush over a misaligned load: flag cleared, bubble inserted
    stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_mem_rdata = 32'h11223344; in_addr_lo = 2'b01;
    in_funct3 = 3'b010; in_wb_src = 3'b001; in_rd = 5'd13; in_reg_write = 1'b1;
    tick();
    chk("mis_pre_flush", wb_misaligned, 1);
    flush = 1'b1;
    drive_alu(1'b1, 32'h7, 5'd14);
    tick();
    chk("flush_mis", wb_misaligned, 0);
    chk("flush_valid", wb_valid, 0);
    chk("flush_instret", instret, 10);
    flush = 1'b0;

    // Reset mid-stream discards the in-flight instruction
    drive_alu(1'b1, 32'h31, 5'd15);
    tick();
    rst = 1'b1;
    drive_alu(1'b1, 32'h32, 5'd16);
    tick();
    rst = 1'b0;
    chk("midrst_valid", wb_valid, 0);
    chk("midrst_rd", wb_rd, 0);
    chk("midrst_instret", instret, 0);

    // Ten valid ALU ops interleaved with three bubbles
    begin
      logic [12:0] pattern;
      pattern = 13'b1110110110111;
      for (int i = 0; i < 13; i++) begin
        drive_alu(pattern[i], 32'(i), 5'd1);
        tick();
      end
    end
    chk("cnt_last_enter", instret, 9);
    drive_alu(1'b0, 32'h0, 5'd0);
    tick();
    chk("cnt_final", instret, 10);
    tick();
    chk("cnt_hold", instret, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register between the memory stage and the writeback result multiplexer of the 32-bit RISC-V core. Each clock it captures the memory-stage result candidates, aligns and sign/zero-extends load data, and registers a 3-bit writeback select. The destination register and write-enable go to the register file. Stall and flush are supported, misaligned loads are flagged, and a retired-instruction counter is maintained.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  replace captured instruction with a bubble
- in_valid  in  1  memory stage holds a real instruction
- in_alu  in  32  ALU result
- in_mem_rdata  in  32  raw aligned 32-bit word from data memory
- in_addr_lo  in  2  low two bits of the load address
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_pc4  in  32  PC+4
- in_imm  in  32  U-type immediate
- in_wb_src  in  3  result source: 000 ALU, 001 load, 010 PC+4, 011 imm, others reserved
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- wb_valid  out  1  registered valid
- wb_sel  out  3  registered select for the result mux
- wb_alu, wb_load, wb_pc4, wb_imm  out  32 each  registered mux data inputs
- wb_rd  out  5  registered destination
- wb_reg_write  out  1  qualified register-file write enable
- wb_misaligned  out  1  registered misaligned-load flag
- instret  out  64  retired-instruction count

## Operation
- **Capture.** On a clock edge with rst=0, stall=0 and flush=0, every wb_* register loads its in_* counterpart. wb_load takes the aligned value described below.
- **Load alignment.** The aligned value is computed combinationally before the register.
  - LB/LBU: select byte in_addr_lo from in_mem_rdata (byte 0 = bits 7:0). Sign-extend for LB, zero-extend for LBU.
  - LH/LHU: select half in_addr_lo[1]. Sign-extend for LH, zero-extend for LHU.
  - LW and any undefined funct3: pass the word unchanged.
- **Misaligned load.** A load is misaligned when in_wb_src=001 and either LH/LHU has in_addr_lo[0]=1, or LW has in_addr_lo≠00.
  - On capture, wb_misaligned is set to 1 and wb_reg_write to 0.
  - The byte/half select still uses the given bits.
- **Write-enable qualification.** wb_reg_write = in_valid & in_reg_write & (in_rd≠0) & ~misaligned.
- **Reserved sources.** in_wb_src 100–111 is registered unchanged into wb_sel. wb_reg_write is forced to 0.
- **Flush.** On flush=1 the next edge sets:
  - wb_valid=0, wb_reg_write=0, wb_misaligned=0, wb_sel=000, wb_rd=0.
  - The data registers may load or hold; their value is don't-care.
- **Stall.** All wb_* registers hold. instret does not advance.
- **Stall and flush together.** Flush wins: a bubble is inserted.
- **instret.**
  - Increments by 1 on each edge where stall=0 and the currently registered wb_valid=1 and wb_misaligned=0.
  - Counts instructions leaving writeback, including ones with no rd write.
  - Wraps from 2^64−1 to 0.

## Timing
- Latency is 1 cycle from in_* to wb_*. All outputs are registered, with no combinational in→out path.
- Reset values, applied on the edge where rst=1 (reset overrides stall and flush):
  - wb_valid=0, wb_sel=000, wb_alu=0, wb_load=0, wb_pc4=0, wb_imm=0, wb_rd=0, wb_reg_write=0, wb_misaligned=0, instret=0.
- Reset mid-stream discards the captured instruction. The instruction present on in_* at that edge is not captured and not counted.
- instret is updated on the same edge that the departing instruction is replaced. It reflects that instruction one cycle later.
- A bubble (in_valid=0) is captured as wb_valid=0 and wb_reg_write=0, and is not counted.

## Test plan
- **Reset.** Hold rst=1 for 2 cycles with random inputs → all outputs 0. Release, then drive an LW with rd=5, in_mem_rdata=0xDEADBEEF, addr_lo=00, wb_src=001 → next cycle wb_load=0xDEADBEEF, wb_sel=001, wb_rd=5, wb_reg_write=1.
- **Load extension.** in_mem_rdata=0x80F17F22 with:
  - LB addr_lo=01 → 0x0000007F
  - LB addr_lo=10 → 0xFFFFFFF1
  - LBU addr_lo=11 → 0x00000080
  - LH addr_lo=10 → 0xFFFF80F1
  - LHU addr_lo=00 → 0x00007F22
- **Misaligned.** LW addr_lo=10 with rd=3 → wb_misaligned=1, wb_reg_write=0, and instret unchanged one cycle after the instruction leaves. LH addr_lo=10 → wb_misaligned=0.
- **rd=0 and reserved source.**
  - ALU op with rd=0, reg_write=1 → wb_reg_write=0, wb_valid=1, instret +1.
  - wb_src=110 → wb_sel=110, wb_reg_write=0.
- **Stall and flush.**
  - Capture ALU result 0x1234, then hold stall=1 for 3 cycles while inputs change → wb_alu stays 0x1234 and instret is frozen.
  - Assert stall=1 and flush=1 together → wb_valid=0, wb_reg_write=0 next cycle.
- **Counter.** Stream 10 valid ALU instructions interleaved with 3 bubbles, no stalls → instret=10 two cycles after the last valid instruction enters.
